pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control block for the 5-stage RV32 core. It tracks the destination-register index of the instructions in EX, MA and WB and drives these indices into the hazard unit. It consumes the hazard unit's data-hazard flag, together with the branch and cache-busy signals, and turns them into per-stage load enables and bubble/flush controls. It also holds a post-reset init sequence and saturating stall/flush performance counters.

## Interface

Parameters:
- RESET_CYCLES, 4: cycles the pipeline is held frozen after reset release (1..255).
- CNT_W, 16: width of each performance counter.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_id_rd  in  5  rd field of the instruction in ID.
- i_id_we  in  1  instruction in ID writes rd.
- i_id_valid  in  1  ID holds a real instruction (not a bubble).
- i_hz_data  in  1  data hazard flag from the hazard unit.
- i_br_taken  in  1  branch/jump in EX redirects the PC this cycle.
- i_ic_miss  in  1  instruction cache cannot deliver this cycle.
- i_dc_busy  in  1  data memory access in MA not complete.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_ex_wb_reg / o_ma_wb_reg / o_wb_wb_reg  out  5 each  destination index per stage; 0 = no writer.
- o_en_if  out  1  PC register load enable.
- o_en_id / o_en_ex / o_en_ma / o_en_wb  out  1 each  load enable of the IF/ID, ID/EX, EX/MA and MA/WB registers.
- o_flush_id / o_flush_ex  out  1 each  load a NOP into IF/ID / ID/EX instead of upstream data.
- o_init  out  1  high while in INIT.
- o_cnt_dstall / o_cnt_mstall / o_cnt_flush  out  CNT_W each  data-stall cycles, memory-wait cycles, branch flushes.

## Operation

State machine:
- INIT is entered on reset and loads the counter with RESET_CYCLES-1.
- INIT decrements each cycle and goes to RUN when the counter is 0.
- RUN is terminal until the next reset.

In INIT:
- All o_en_* = 0.
- o_flush_id = o_flush_ex = 1.
- Tracker registers hold 0.
- Counters do not increment.

In RUN, the cause is chosen per cycle, highest priority first:
1. i_dc_busy (memory wait): all enables 0, no flush. Tracker frozen. mstall increments.
2. i_br_taken (branch flush): all enables 1, flush_id = flush_ex = 1. i_hz_data and i_ic_miss are ignored because ID is wrong-path. flush increments once.
3. i_hz_data (data stall): en_if = en_id = 0; en_ex = en_ma = en_wb = 1, flush_ex = 1. dstall increments.
4. i_ic_miss (fetch bubble): en_if = 0, other enables 1, flush_id = 1.
5. Otherwise (normal): all enables 1, no flush.

Tracker update, on an edge where the stage enable is 1:
- ex ← (i_id_valid & i_id_we & ~flush_ex) ? i_id_rd : 0.
- ma ← ex.
- wb ← ma.
- rd = x0 propagates as 0. This is harmless because the hazard unit ignores index 0.

Counters:
- Saturate at all-ones and never wrap.
- i_cnt_clr wins over a same-cycle increment. The result is 0, not 1.

## Timing

- Enables and flushes are combinational from the inputs and the current state, and valid in the same cycle.
- Tracker outputs and counters are registered and change only on the rising edge of i_clk.
- No combinational path exists from i_hz_data to o_*_wb_reg, so there is no loop through the hazard unit.
- A branch held during i_dc_busy stays in EX because EX is frozen. It is re-evaluated on the first non-busy cycle and counted exactly once.
- A hazard still present after a stall is re-flagged by the hazard unit from the updated tracker. The block adds no extra stall cycles of its own.
- Reset values: tracker outputs 0, all counters 0, o_init = 1, all enables 0, both flushes 1.
- Asserting i_rst_n low mid-operation returns the block to INIT immediately, asynchronously, regardless of state.

## Structure

- State encodings (INIT, RUN) and the NO_REG index (5'd0) are defined in a shared header included alongside config.v. The stage-cause encoding is defined there too if it is exported for debug.
- One sub-module, sat_counter, is parameterised on CNT_W with inc and clr inputs. It is instantiated three times.
- Tracker, FSM and priority decode stay in pipe_ctrl.

## Test plan

- Reset release with RESET_CYCLES = 4 → o_init high for exactly 4 cycles, enables 0 throughout, then all enables 1 with no stall inputs.
- Writer of rd = 5 then i_hz_data for 2 cycles → en_if/en_id low for 2 cycles; o_ex_wb_reg = 0 on both bubbles; o_ma_wb_reg = 5 after the first bubble and o_wb_wb_reg = 5 after the second; o_cnt_dstall = 2.
- i_br_taken together with i_hz_data and i_ic_miss → flush_id = flush_ex = 1, all enables 1; next o_ex_wb_reg = 0; o_cnt_flush = 1, dstall unchanged.
- i_dc_busy for 3 cycles with i_br_taken held → all enables 0 for 3 cycles, tracker unchanged; flush applied on cycle 4 only; mstall = 3, flush = 1.
- CNT_W = 4 with 20 hazard cycles → o_cnt_dstall saturates at 15; i_cnt_clr during a hazard cycle → 0 on the next edge.
- Reset asserted mid-stall → outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipe_ctrl_pkg;

    // Controller state: frozen after reset, then running.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Per-cycle reason for the enable/flush pattern, exported for debug.
    typedef enum logic [2:0] {
        CS_INIT   = 3'd0,
        CS_MEM    = 3'd1,
        CS_BRANCH = 3'd2,
        CS_DATA   = 3'd3,
        CS_FETCH  = 3'd4,
        CS_NONE   = 3'd5
    } cause_t;

    // Destination index meaning "no writer"; x0 collapses onto it.
    localparam logic [4:0] NO_REG = 5'd0;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up, holding at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: post-reset freeze, stall/flush priority decode,
// destination-register tracking for EX/MA/WB and performance counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | pipeline frozen, NOPs injected, down-counter running to 0
// ST_RUN  | normal operation, enables/flushes from priority decode
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_we,
    input  logic             i_id_valid,
    input  logic             i_hz_data,
    input  logic             i_br_taken,
    input  logic             i_ic_miss,
    input  logic             i_dc_busy,
    input  logic             i_cnt_clr,
    output logic [4:0]       o_ex_wb_reg,
    output logic [4:0]       o_ma_wb_reg,
    output logic [4:0]       o_wb_wb_reg,
    output logic             o_en_if,
    output logic             o_en_id,
    output logic             o_en_ex,
    output logic             o_en_ma,
    output logic             o_en_wb,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_init,
    output logic [CNT_W-1:0] o_cnt_dstall,
    output logic [CNT_W-1:0] o_cnt_mstall,
    output logic [CNT_W-1:0] o_cnt_flush
);

    localparam logic [7:0] INIT_LOAD = 8'(RESET_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_init_cnt;
    cause_t     w_cause;

    logic       w_en_if, w_en_id, w_en_ex, w_en_ma, w_en_wb;
    logic       w_flush_id, w_flush_ex;
    logic [4:0] w_ex_nxt;

    logic [4:0] r_ex_rd, r_ma_rd, r_wb_rd;

    // State register and init down-counter; reset reloads the freeze length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= INIT_LOAD;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_INIT) && (r_init_cnt != 8'd0)) begin
                r_init_cnt <= r_init_cnt - 8'd1;
            end
        end
    end

    // Next state, cause priority and the resulting enable/flush pattern.
    always_comb begin
        w_state_nxt = r_state;
        w_cause     = CS_NONE;
        w_en_if     = 1'b1;
        w_en_id     = 1'b1;
        w_en_ex     = 1'b1;
        w_en_ma     = 1'b1;
        w_en_wb     = 1'b1;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;

        if (r_state == ST_INIT) begin
            w_cause = CS_INIT;
            if (r_init_cnt == 8'd0) begin
                w_state_nxt = ST_RUN;
            end
        end else if (i_dc_busy) begin
            w_cause = CS_MEM;
        end else if (i_br_taken) begin
            // ID is wrong-path here, so its hazard/miss flags are moot.
            w_cause = CS_BRANCH;
        end else if (i_hz_data) begin
            w_cause = CS_DATA;
        end else if (i_ic_miss) begin
            w_cause = CS_FETCH;
        end

        case (w_cause)
            CS_INIT: begin
                {w_en_if, w_en_id, w_en_ex, w_en_ma, w_en_wb} = 5'b00000;
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end
            CS_MEM: begin
                {w_en_if, w_en_id, w_en_ex, w_en_ma, w_en_wb} = 5'b00000;
            end
            CS_BRANCH: begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end
            CS_DATA: begin
                w_en_if    = 1'b0;
                w_en_id    = 1'b0;
                w_flush_ex = 1'b1;
            end
            CS_FETCH: begin
                w_en_if    = 1'b0;
                w_flush_id = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_ex_nxt = (i_id_valid && i_id_we && !w_flush_ex) ? i_id_rd : NO_REG;

    // Destination tracker; each stage advances only with its enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_rd <= NO_REG;
            r_ma_rd <= NO_REG;
            r_wb_rd <= NO_REG;
        end else if (r_state == ST_INIT) begin
            r_ex_rd <= NO_REG;
            r_ma_rd <= NO_REG;
            r_wb_rd <= NO_REG;
        end else begin
            if (w_en_ex) r_ex_rd <= w_ex_nxt;
            if (w_en_ma) r_ma_rd <= r_ex_rd;
            if (w_en_wb) r_wb_rd <= r_ma_rd;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_dstall (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_cause == CS_DATA),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_cnt_dstall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mstall (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_cause == CS_MEM),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_cnt_mstall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_cause == CS_BRANCH),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_cnt_flush)
    );

    assign o_ex_wb_reg = r_ex_rd;
    assign o_ma_wb_reg = r_ma_rd;
    assign o_wb_wb_reg = r_wb_rd;
    assign o_en_if     = w_en_if;
    assign o_en_id     = w_en_id;
    assign o_en_ex     = w_en_ex;
    assign o_en_ma     = w_en_ma;
    assign o_en_wb     = w_en_wb;
    assign o_flush_id  = w_flush_id;
    assign o_flush_ex  = w_flush_ex;
    assign o_init      = (r_state == ST_INIT);

endmodule
